// File: rtl/coa_pkg.sv
// Shared COA types: result width, angle class and collector state encodings.
package coa_pkg;

    localparam int COA_D_W = 10;

    typedef enum logic [1:0] {
        CLS_ACUTE  = 2'd0,
        CLS_RIGHT  = 2'd1,
        CLS_OBTUSE = 2'd2
    } coa_class_e;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } coll_state_e;

endpackage

// File: rtl/coa_stat_collector_if.sv
// COA sample stream in, per-frame report out (valid/ready), plus status flags.
interface coa_stat_collector_if
    import coa_pkg::*;
#(
    parameter int DATA_W = COA_D_W,
    parameter int CNT_W  = 5,
    parameter int SUM_W  = 14
);
    logic              coa_valid;
    logic [DATA_W-1:0] coa_d;
    logic              flush;
    logic              rpt_ready;
    logic              rpt_valid;
    logic [CNT_W-1:0]  rpt_acute;
    logic [CNT_W-1:0]  rpt_right;
    logic [CNT_W-1:0]  rpt_obtuse;
    logic [DATA_W-1:0] rpt_max;
    logic [DATA_W-1:0] rpt_min;
    logic [SUM_W-1:0]  rpt_sum;
    logic              overrun;
    logic              busy;

    modport master (
        output coa_valid, coa_d, flush, rpt_ready,
        input  rpt_valid, rpt_acute, rpt_right, rpt_obtuse,
        input  rpt_max, rpt_min, rpt_sum, overrun, busy
    );

    modport slave (
        input  coa_valid, coa_d, flush, rpt_ready,
        output rpt_valid, rpt_acute, rpt_right, rpt_obtuse,
        output rpt_max, rpt_min, rpt_sum, overrun, busy
    );
endinterface

// File: rtl/coa_angle_classify.sv
// Classifies the angle at A from the sign of D: >0 acute, ==0 right, <0 obtuse.
// Latency: combinational.
// Backpressure: none.
module coa_angle_classify
    import coa_pkg::*;
#(
    parameter int DATA_W = COA_D_W
) (
    input  logic [DATA_W-1:0] coa_d,
    output coa_class_e        cls
);
    always_comb begin
        if (coa_d[DATA_W-1]) begin
            cls = CLS_OBTUSE;
        end else if (coa_d == '0) begin
            cls = CLS_RIGHT;
        end else begin
            cls = CLS_ACUTE;
        end
    end
endmodule

// File: rtl/coa_stat_collector.sv
// Per-frame angle-class statistics (counts, signed min/max/sum) over FRAME_LEN COA samples.
// Latency: report valid 1 cycle after the closing sample.
// Backpressure: none on input; an unread report is overwritten by the next frame, setting overrun.
module coa_stat_collector
    import coa_pkg::*;
#(
    parameter int DATA_W    = COA_D_W,
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = $clog2(FRAME_LEN + 1),
    parameter int SUM_W     = DATA_W + $clog2(FRAME_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    coa_stat_collector_if.slave bus
);
    localparam int                 IDX_W  = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(FRAME_LEN - 1);
    localparam logic [DATA_W-1:0]  MAX_ID = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0]  MIN_ID = {1'b0, {(DATA_W-1){1'b1}}};

    coll_state_e              state_q, state_d;
    coa_class_e               cls;
    logic                     accept, close;
    logic [IDX_W-1:0]         idx_q;
    logic [CNT_W-1:0]         acute_q, right_q, obtuse_q;
    logic [CNT_W-1:0]         acute_d, right_d, obtuse_d;
    logic signed [DATA_W-1:0] d_s, max_q, min_q, max_d, min_d;
    logic signed [SUM_W-1:0]  sum_q, sum_d;

    logic                     rpt_valid_q, overrun_q;
    logic [CNT_W-1:0]         rpt_acute_q, rpt_right_q, rpt_obtuse_q;
    logic [DATA_W-1:0]        rpt_max_q, rpt_min_q;
    logic [SUM_W-1:0]         rpt_sum_q;

    coa_angle_classify #(.DATA_W(DATA_W)) u_classify (
        .coa_d (bus.coa_d),
        .cls   (cls)
    );

    // flush beats a coincident sample, including the one that would close the frame
    assign d_s    = bus.coa_d;
    assign accept = bus.coa_valid & ~bus.flush;
    assign close  = accept && (idx_q == IDX_LAST);

    always_comb begin
        acute_d  = acute_q  + CNT_W'(cls == CLS_ACUTE);
        right_d  = right_q  + CNT_W'(cls == CLS_RIGHT);
        obtuse_d = obtuse_q + CNT_W'(cls == CLS_OBTUSE);
        max_d    = (d_s > max_q) ? d_s : max_q;
        min_d    = (d_s < min_q) ? d_s : min_q;
        sum_d    = sum_q + SUM_W'(d_s);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ACCUM;
            ACCUM:   if (bus.flush || close) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_q == ACCUM);
    end

    // Closing edge hands the updated stats to the report slot and restarts at identity
    always_ff @(posedge clk) begin
        if (rst || bus.flush || close) begin
            idx_q    <= '0;
            acute_q  <= '0;
            right_q  <= '0;
            obtuse_q <= '0;
            max_q    <= MAX_ID;
            min_q    <= MIN_ID;
            sum_q    <= '0;
        end else if (accept) begin
            idx_q    <= idx_q + 1'b1;
            acute_q  <= acute_d;
            right_q  <= right_d;
            obtuse_q <= obtuse_d;
            max_q    <= max_d;
            min_q    <= min_d;
            sum_q    <= sum_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
            rpt_acute_q  <= '0;
            rpt_right_q  <= '0;
            rpt_obtuse_q <= '0;
            rpt_max_q    <= '0;
            rpt_min_q    <= '0;
            rpt_sum_q    <= '0;
        end else if (close) begin
            rpt_valid_q  <= 1'b1;
            rpt_acute_q  <= acute_d;
            rpt_right_q  <= right_d;
            rpt_obtuse_q <= obtuse_d;
            rpt_max_q    <= max_d;
            rpt_min_q    <= min_d;
            rpt_sum_q    <= sum_d;
            if (rpt_valid_q && !bus.rpt_ready) begin
                overrun_q <= 1'b1;
            end
        end else if (rpt_valid_q && bus.rpt_ready) begin
            rpt_valid_q <= 1'b0;
        end
    end

    assign bus.rpt_valid  = rpt_valid_q;
    assign bus.rpt_acute  = rpt_acute_q;
    assign bus.rpt_right  = rpt_right_q;
    assign bus.rpt_obtuse = rpt_obtuse_q;
    assign bus.rpt_max    = rpt_max_q;
    assign bus.rpt_min    = rpt_min_q;
    assign bus.rpt_sum    = rpt_sum_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_coa_stat_collector.sv
// Scoreboard bench: a behavioural frame model pushes expected reports; a negedge monitor pops them on handshake.
module tb_coa_stat_collector;
    import coa_pkg::*;

    localparam int DATA_W = 10;
    localparam int FLEN   = 16;
    localparam int CNT_W  = 5;
    localparam int SUM_W  = 14;

    typedef struct {
        int acute;
        int right;
        int obtuse;
        int mx;
        int mn;
        int sum;
    } rpt_t;

    logic clk;
    logic rst;
    coa_stat_collector_if #(.DATA_W(DATA_W), .CNT_W(CNT_W), .SUM_W(SUM_W)) bus ();

    coa_stat_collector #(
        .DATA_W(DATA_W), .FRAME_LEN(FLEN), .CNT_W(CNT_W), .SUM_W(SUM_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    rpt_t sb[$];
    int   m_acute, m_right, m_obtuse, m_max, m_min, m_sum, m_idx;
    bit   exp_ovr;
    bit   rdy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_acute = 0; m_right = 0; m_obtuse = 0;
        m_max = -512; m_min = 511; m_sum = 0; m_idx = 0;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.rpt_valid && bus.rpt_ready) begin
            chk("sb_avail", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                rpt_t e;
                e = sb.pop_front();
                chk("rpt_acute",  bus.rpt_acute,           e.acute);
                chk("rpt_right",  bus.rpt_right,           e.right);
                chk("rpt_obtuse", bus.rpt_obtuse,          e.obtuse);
                chk("rpt_max",    $signed(bus.rpt_max),    e.mx);
                chk("rpt_min",    $signed(bus.rpt_min),    e.mn);
                chk("rpt_sum",    $signed(bus.rpt_sum),    e.sum);
            end
        end
    end

    task automatic drive_cycle(input bit v, input int d, input bit fl);
        bus.coa_valid = v;
        bus.coa_d     = DATA_W'(d);
        bus.flush     = fl;
        bus.rpt_ready = rdy;
        if (fl) begin
            model_clear();
        end else if (v) begin
            if (d > 0) m_acute++;
            else if (d == 0) m_right++;
            else m_obtuse++;
            if (d > m_max) m_max = d;
            if (d < m_min) m_min = d;
            m_sum += d;
            m_idx++;
            if (m_idx == FLEN) begin
                if (!rdy && sb.size() != 0) begin
                    void'(sb.pop_front());
                    exp_ovr = 1'b1;
                end
                sb.push_back('{m_acute, m_right, m_obtuse, m_max, m_min, m_sum});
                model_clear();
            end
        end
        @(posedge clk);
        #1;
        chk("busy",      bus.busy,      m_idx != 0);
        chk("rpt_valid", bus.rpt_valid, sb.size() != 0);
        chk("overrun",   bus.overrun,   exp_ovr);
    endtask

    task automatic idle(input int n);
        repeat (n) drive_cycle(1'b0, 0, 1'b0);
    endtask

    task automatic send_list(input int vals[$], input int max_gap);
        foreach (vals[i]) begin
            drive_cycle(1'b1, vals[i], 1'b0);
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) drive_cycle(1'b0, 0, 1'b0);
        end
    endtask

    task automatic send_const(input int val, input int n);
        repeat (n) drive_cycle(1'b1, val, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rdy = 1'b0;
        bus.coa_valid = 1'b0;
        bus.coa_d     = '0;
        bus.flush     = 1'b0;
        bus.rpt_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_rpt_valid",  bus.rpt_valid,  0);
        chk("rst_rpt_acute",  bus.rpt_acute,  0);
        chk("rst_rpt_right",  bus.rpt_right,  0);
        chk("rst_rpt_obtuse", bus.rpt_obtuse, 0);
        chk("rst_rpt_max",    bus.rpt_max,    0);
        chk("rst_rpt_min",    bus.rpt_min,    0);
        chk("rst_rpt_sum",    bus.rpt_sum,    0);
        chk("rst_overrun",    bus.overrun,    0);
        chk("rst_busy",       bus.busy,       0);
        sb.delete();
        model_clear();
        exp_ovr = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int pat[$];
        rst = 1'b1;
        do_reset();

        // reset mid-frame with a report pending
        rdy = 1'b0;
        send_const(2, FLEN);
        send_const(3, 7);
        do_reset();

        for (int i = 0; i < 8; i++) pat.push_back(5);
        for (int i = 0; i < 4; i++) pat.push_back(0);
        for (int i = 0; i < 4; i++) pat.push_back(-3);

        rdy = 1'b1;
        send_list(pat, 0);
        idle(2);

        send_list(pat, 3);
        idle(2);

        // two unread frames: second overwrites the first
        rdy = 1'b0;
        send_list(pat, 0);
        send_const(1, FLEN);
        chk("t4_acute",  bus.rpt_acute,        16);
        chk("t4_obtuse", bus.rpt_obtuse,       0);
        chk("t4_max",    $signed(bus.rpt_max), 1);
        chk("t4_min",    $signed(bus.rpt_min), 1);
        chk("t4_sum",    $signed(bus.rpt_sum), 16);
        rdy = 1'b1;
        drive_cycle(1'b0, 0, 1'b0);
        rdy = 1'b0;
        idle(1);
        do_reset();

        // flush drops the coincident sample and the partial frame
        rdy = 1'b1;
        send_const(100, 5);
        drive_cycle(1'b1, 50, 1'b1);
        send_const(511, FLEN);
        idle(2);

        send_const(-512, FLEN);
        idle(2);

        // flush on the closing sample: no report
        send_const(7, FLEN - 1);
        drive_cycle(1'b1, 7, 1'b1);
        idle(2);

        // close while full with reader accepting in the same cycle
        rdy = 1'b0;
        send_const(4, FLEN);
        send_const(-1, FLEN - 1);
        rdy = 1'b1;
        drive_cycle(1'b1, -1, 1'b0);
        idle(2);

        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
